// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, with
// signed-overflow and carry/borrow flags registered at completion.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             mode_r, carry;
    logic [CW-1:0]    cnt;
    logic             b_bit, sum_bit, carry_nx, last_bit, accept;

    always_comb begin
        b_bit    = b_sr[0] ^ mode_r;
        sum_bit  = a_sr[0] ^ b_bit ^ carry;
        carry_nx = (a_sr[0] & b_bit) | (a_sr[0] & carry) | (b_bit & carry);
        last_bit = (cnt == CW'(WIDTH - 1));
        // abort only vetoes a start when it arrives during DONE
        accept   = start && ((state == IDLE) || (state == DONE && !abort));
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)         state_nx = IDLE;
                else if (last_bit) state_nx = DONE;
            end
            DONE: begin
                ready    = 1'b1;
                done     = 1'b1;
                state_nx = accept ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            mode_r    <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                mode_r <= mode;
                carry  <= mode;
                cnt    <= '0;
            end else if (state == RUN && !abort) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                sum_sr <= {sum_bit, sum_sr[WIDTH-1:1]};
                carry  <= carry_nx;
                cnt    <= last_bit ? '0 : cnt + CW'(1);
                // final bit goes straight to result so partial sums never show
                if (last_bit) begin
                    result    <= {sum_bit, sum_sr[WIDTH-1:1]};
                    carry_out <= carry_nx;
                    overflow  <= carry ^ carry_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed vector table and corner-case sequences on WIDTH=8, plus a random
// sweep run in lockstep on WIDTH=2, 8 and 32 instances.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n, start, mode, abort;
    logic [31:0] a_in, b_in;

    logic        rdy2, bsy2, dn2, co2, ov2;
    logic [1:0]  res2;
    logic        rdy8, bsy8, dn8, co8, ov8;
    logic [7:0]  res8;
    logic        rdy32, bsy32, dn32, co32, ov32;
    logic [31:0] res32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .a(a_in[1:0]), .b(b_in[1:0]), .ready(rdy2), .busy(bsy2), .done(dn2),
        .result(res2), .carry_out(co2), .overflow(ov2));

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .a(a_in[7:0]), .b(b_in[7:0]), .ready(rdy8), .busy(bsy8), .done(dn8),
        .result(res8), .carry_out(co8), .overflow(ov8));

    serial_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .a(a_in), .b(b_in), .ready(rdy32), .busy(bsy32), .done(dn32),
        .result(res32), .carry_out(co32), .overflow(ov32));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {carry, overflow, result} for a WIDTH-w operation.
    function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic m);
        longint unsigned mask, xa, yb, s, r;
        logic sa, sb, sr;
        mask = (64'd1 << w) - 1;
        xa   = longint'(x) & mask;
        yb   = (m ? ~longint'(y) : longint'(y)) & mask;
        s    = xa + yb + longint'(m);
        r    = s & mask;
        sa   = xa[w-1];
        sb   = yb[w-1];
        sr   = r[w-1];
        return {s[w], (sa == sb) && (sr != sa), r[31:0]};
    endfunction

    // Drives a one-cycle start, returns edges counted until done on dut8.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic m,
                          output int n);
        a_in  = {24'h0, x};
        b_in  = {24'h0, y};
        mode  = m;
        start = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            if (dn8) break;
        end
    endtask

    task automatic count_dones(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (dn8) seen++;
        end
    endtask

    initial begin
        vec_t        vecs[9];
        int          n, seen;
        logic [31:0] ra, rb;
        logic        rm, g2, g8, g32;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[5] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        a_in = '0; b_in = '0;
        #2;
        chk("reset_outputs", {rdy8, bsy8, dn8, res8, co8, ov8}, {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        #1 rst_n = 1'b1;

        // first start accepted on the first edge after release, inside the table loop
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, n);
            chk($sformatf("vec%0d_latency", i), 64'(n), 64'd9);
            chk($sformatf("vec%0d_result", i), {co8, ov8, res8}, {vecs[i].c, vecs[i].v, vecs[i].r});
        end

        // back-to-back: start held across DONE
        run_op(8'h7F, 8'h01, 1'b0, n);
        a_in = 32'hFF; b_in = 32'h01; mode = 1'b0; start = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            if (dn8) break;
        end
        chk("b2b_spacing", 64'(n), 64'd9);
        chk("b2b_result", {co8, ov8, res8}, {1'b1, 1'b0, 8'h00});

        // start during RUN is ignored
        a_in = 32'h10; b_in = 32'h20; mode = 1'b0; start = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            start = 1'b0;
            if (n == 3) begin
                start = 1'b1; a_in = 32'h55; b_in = 32'h55; mode = 1'b1;
            end
            if (dn8) break;
        end
        start = 1'b0;
        chk("ignore_start_latency", 64'(n), 64'd9);
        chk("ignore_start_result", {co8, ov8, res8}, {1'b0, 1'b0, 8'h30});

        // abort at RUN cycle 4
        a_in = 32'h12; b_in = 32'h34; mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            start = 1'b0;
        end
        chk("abort_busy_before", 64'(bsy8), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", {rdy8, bsy8, dn8}, {1'b1, 1'b0, 1'b0});
        count_dones(12, seen);
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_result_kept", {co8, ov8, res8}, {1'b0, 1'b0, 8'h30});

        // abort in DONE blocks a simultaneous start
        run_op(8'h01, 8'h01, 1'b0, n);
        chk("pre_abort_done", 64'(dn8), 64'd1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_in_done", {rdy8, bsy8, dn8}, {1'b1, 1'b0, 1'b0});
        count_dones(12, seen);
        chk("abort_in_done_quiet", 64'(seen), 64'd0);
        chk("abort_in_done_result", {co8, ov8, res8}, {1'b0, 1'b0, 8'h02});

        // asynchronous reset at RUN cycle 5
        a_in = 32'h7F; b_in = 32'h01; mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {rdy8, bsy8, dn8, res8, co8, ov8}, {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tick();
        #2 rst_n = 1'b1;
        count_dones(12, seen);
        chk("reset_no_done", 64'(seen), 64'd0);
        chk("reset_result", {rdy8, res8}, {1'b1, 8'h00});

        // random sweep on all three widths in lockstep
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom; rb = $urandom; rm = 1'($urandom_range(0, 1));
            a_in = ra; b_in = rb; mode = rm; start = 1'b1;
            g2 = 1'b0; g8 = 1'b0; g32 = 1'b0;
            for (int t = 0; t < 40; t++) begin
                tick();
                start = 1'b0;
                if (dn2 && !g2) begin
                    g2 = 1'b1;
                    chk("sweep_w2", {co2, ov2, 30'h0, res2}, model(2, ra, rb, rm));
                end
                if (dn8 && !g8) begin
                    g8 = 1'b1;
                    chk("sweep_w8", {co8, ov8, 24'h0, res8}, model(8, ra, rb, rm));
                end
                if (dn32 && !g32) begin
                    g32 = 1'b1;
                    chk("sweep_w32", {co32, ov32, res32}, model(32, ra, rb, rm));
                end
                if (g2 && g8 && g32) break;
            end
            if (!(g2 && g8 && g32)) chk("sweep_timeout", {g2, g8, g32}, 3'b111);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock, the block's only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled on a rising clk edge.
REQ-005 mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 abort  input  1  synchronous cancel of an operation in progress.
REQ-007 a  input  WIDTH  first operand; sampled with start.
REQ-008 b  input  WIDTH  second operand; sampled with start.
REQ-009 ready  output  1  high when start will be accepted.
REQ-010 busy  output  1  high while bits are being processed.
REQ-011 done  output  1  single-cycle pulse marking a valid result.
REQ-012 result  output  WIDTH  registered sum or difference.
REQ-013 carry_out  output  1  final carry; for subtract, 1 means no borrow.
REQ-014 overflow  output  1  two's-complement signed overflow of the last operation.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 ready SHALL be 1 in IDLE and in DONE, and 0 in RUN.
REQ-017 busy SHALL be 1 only in RUN.
REQ-018 done SHALL be 1 only in DONE.
REQ-019 When start=1 and ready=1, the block SHALL latch a, b and mode into internal shift registers, set the internal carry to mode, clear the bit counter, and enter RUN.
REQ-020 In RUN, each cycle SHALL process one bit, LSB first.
REQ-021 Bit i SHALL be computed as sum = a_i XOR b'_i XOR c and c_next = majority(a_i, b'_i, c), where b'_i = b_i XOR mode.
REQ-022 After bit WIDTH-1 is processed, the FSM SHALL enter DONE on the next edge.
REQ-023 On that edge, result, carry_out and overflow SHALL be loaded. overflow = (carry into MSB) XOR (carry out of MSB).
REQ-024 Latency: start accepted at edge T -> done=1 during the cycle after edge T+WIDTH, i.e. WIDTH+1 cycles after acceptance.
REQ-025 DONE SHALL last exactly one cycle. It goes to RUN if start=1 (back-to-back operation), otherwise to IDLE.
REQ-026 result, carry_out and overflow SHALL hold their values until the next completed operation; intermediate bits are never visible on result.
REQ-027 start while in RUN SHALL be ignored; the operands of the operation in progress are unaffected.
REQ-028 abort=1 in RUN SHALL return the FSM to IDLE on the next edge, with no done pulse and result/carry_out/overflow unchanged.
REQ-029 abort in IDLE or DONE SHALL have no effect, except that abort=1 in DONE blocks a simultaneous start. abort has priority over start.
REQ-030 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during an operation.
REQ-031 mode, a and b changing during RUN SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=IDLE, ready=1, busy=0, done=0, result=0, carry_out=0, overflow=0, and clear all internal registers.
REQ-033 Reset asserted in RUN or DONE SHALL discard the operation in progress, with no done pulse after release.
REQ-034 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification (WIDTH=8)
REQ-035 Add: a=8'h7F, b=8'h01, mode=0 -> done 9 cycles after acceptance; result=8'h80, carry_out=0, overflow=1.
REQ-036 Subtract borrow: a=8'h00, b=8'h01, mode=1 -> result=8'hFF, carry_out=0, overflow=0. Then a=8'h80, b=8'h01, mode=1 -> result=8'h7F, carry_out=1, overflow=1.
REQ-037 Back-to-back: start held high across DONE with new operands 8'hFF+8'h01 -> second done exactly 9 cycles after the first; result=8'h00, carry_out=1, overflow=0.
REQ-038 Abort: abort=1 at cycle 4 of RUN -> no done pulse, result keeps its prior value, ready=1 on the next cycle. A start 3 cycles into RUN (operands 8'h55) is ignored.
REQ-039 Reset mid-RUN: rst_n=0 at cycle 5 -> all outputs at reset values immediately (asynchronously). After release, no done pulse occurs.
REQ-040 Random sweep: at least 1000 random a/b/mode operations compared against a reference model for result, carry_out and overflow, at WIDTH=2, 8 and 32.
